// File: rtl/dmem_arbiter.sv
// Shares the data-memory/peripheral bus between the CPU and a DMA requester.
// The CPU wins by default; a starved DMA takes a bounded forced burst that stalls the CPU.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_wr,
  input  logic             dma_last,
  input  logic [31:0]      dma_addr,
  input  logic [31:0]      dma_wdata,
  output logic             dma_gnt,
  output logic [31:0]      dma_rdata,
  output logic             dma_rvalid,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             dbg_state
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int unsigned BEAT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);
  localparam bit CAN_FORCE = (BURST_MAX > 1);

  typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [31:0]       dma_rdata_q;
  logic              dma_rvalid_q;
  logic              cpu_acc, forced, cpu_own;

  // DMA handshake: dma_req is held with stable beat fields until dma_gnt; a beat
  // transfers in the cycle where dma_req and dma_gnt are both high.
  assign cpu_acc   = cpu_rd | cpu_wr;
  assign forced    = (state_q == FORCE) | (dma_req & (wait_cnt_q == WAIT_MAX));
  assign dma_gnt   = dma_req & (forced | ~cpu_acc);
  assign cpu_stall = dma_gnt & cpu_acc;
  assign cpu_own   = ~dma_gnt & cpu_acc;
  assign cpu_rdata = cpu_own ? mem_rdata : 32'h0;

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (dma_gnt) begin
      mem_rd    = ~dma_wr;
      mem_wr    = dma_wr;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (cpu_acc) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      NORMAL: begin
        if (dma_gnt) begin
          wait_cnt_d = '0;
          if ((wait_cnt_q == WAIT_MAX) && !dma_last && CAN_FORCE) begin
            state_d    = FORCE;
            beat_cnt_d = BEAT_W'(1);
          end
        end else if (dma_req) begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      FORCE: begin
        // Every requested cycle in FORCE is granted, so only the exit terms matter.
        if (!dma_req || dma_last || (beat_cnt_q == BEAT_LAST)) begin
          state_d    = NORMAL;
          beat_cnt_d = '0;
          wait_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= NORMAL;
      wait_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      dma_rdata_q  <= 32'h0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      dma_rvalid_q <= dma_gnt & ~dma_wr;
      if (dma_gnt && !dma_wr) dma_rdata_q <= mem_rdata;
      if (cpu_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: default instance (a_*) and MAX_WAIT=0/BURST_MAX=1 instance (b_*).
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        cpu_rd, cpu_wr, dma_req, dma_wr, dma_last;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

  logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata;
  logic        a_cpu_stall, a_dma_gnt, a_dma_rvalid, a_mem_rd, a_mem_wr, a_dbg_state;
  logic [15:0] a_stall_cnt;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata;
  logic        b_cpu_stall, b_dma_gnt, b_dma_rvalid, b_mem_rd, b_mem_wr, b_dbg_state;
  logic [15:0] b_stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  dmem_arbiter #(.MAX_WAIT(8), .BURST_MAX(4), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(a_dma_gnt), .dma_rdata(a_dma_rdata),
    .dma_rvalid(a_dma_rvalid), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(a_stall_cnt),
    .dbg_state(a_dbg_state)
  );

  dmem_arbiter #(.MAX_WAIT(0), .BURST_MAX(1), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(b_dma_gnt), .dma_rdata(b_dma_rdata),
    .dma_rvalid(b_dma_rvalid), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(b_stall_cnt),
    .dbg_state(b_dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic drive_idle();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_wr = 1'b0; dma_last = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_contention(input logic wr);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h0;
    dma_req = 1'b1; dma_wr = wr; dma_last = 1'b0; dma_addr = 32'h200; dma_wdata = 32'h77;
    mem_rdata = 32'hCAFEF00D;
  endtask

  // Tests
  task automatic test_reset();
    drive_idle();
    mem_rdata = 32'h0;
    reset = 1'b0;
    #12;
    vectors++;
    if ({a_dbg_state, a_dma_rvalid, a_mem_rd, a_mem_wr, a_dma_gnt, a_cpu_stall} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000",
               {a_dbg_state, a_dma_rvalid, a_mem_rd, a_mem_wr, a_dma_gnt, a_cpu_stall});
    end
    vectors++;
    if ({a_stall_cnt, a_dma_rdata, a_mem_addr} !== 80'h0) begin
      miscompares++;
      $display("FAIL reset_values: stall_cnt=%h dma_rdata=%h mem_addr=%h want 0",
               a_stall_cnt, a_dma_rdata, a_mem_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_cpu_passthrough();
    cpu_wr = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h55AA;
    @(negedge clk);
    vectors++;
    if ({a_mem_rd, a_mem_wr, a_dma_gnt, a_cpu_stall, a_mem_addr, a_mem_wdata} !== {4'b0100, 32'h44, 32'h55AA}) begin
      miscompares++;
      $display("FAIL cpu_store: rd/wr/gnt/stall=%b addr=%h wdata=%h want 0100 44 55aa",
               {a_mem_rd, a_mem_wr, a_dma_gnt, a_cpu_stall}, a_mem_addr, a_mem_wdata);
    end
    step();
    cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 32'h48; mem_rdata = 32'h0BADCAFE;
    @(negedge clk);
    vectors++;
    if ({a_mem_rd, a_mem_wr, a_mem_addr, a_cpu_rdata} !== {2'b10, 32'h48, 32'h0BADCAFE}) begin
      miscompares++;
      $display("FAIL cpu_load: rd/wr=%b addr=%h rdata=%h want 10 48 0badcafe",
               {a_mem_rd, a_mem_wr}, a_mem_addr, a_cpu_rdata);
    end
    step();
    drive_idle();
    @(negedge clk);
    vectors++;
    if ({a_mem_rd, a_mem_wr, a_mem_addr, a_mem_wdata, a_cpu_rdata} !== 98'h0) begin
      miscompares++;
      $display("FAIL bus_idle: rd/wr=%b addr=%h wdata=%h cpu_rdata=%h want all 0",
               {a_mem_rd, a_mem_wr}, a_mem_addr, a_mem_wdata, a_cpu_rdata);
    end
    step();
  endtask

  task automatic test_dma_idle_write();
    dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 32'h10; dma_wdata = 32'hA5;
    @(negedge clk);
    vectors++;
    if ({a_dma_gnt, a_cpu_stall, a_mem_rd, a_mem_wr, a_mem_addr, a_mem_wdata, a_stall_cnt}
        !== {4'b1001, 32'h10, 32'hA5, 16'h0}) begin
      miscompares++;
      $display("FAIL dma_idle_write: gnt/stall/rd/wr=%b addr=%h wdata=%h stall_cnt=%0d want 1001 10 a5 0",
               {a_dma_gnt, a_cpu_stall, a_mem_rd, a_mem_wr}, a_mem_addr, a_mem_wdata, a_stall_cnt);
    end
    step();
    drive_idle();
    step();
  endtask

  task automatic test_forced_burst();
    logic        eg, es;
    logic [15:0] ec;
    drive_contention(1'b1);
    for (int c = 0; c <= 12; c++) begin
      eg = (c >= 8) && (c <= 11);
      es = (c >= 9) && (c <= 11);
      ec = (c <= 8) ? 16'd0 : 16'(c - 8);
      @(negedge clk);
      vectors++;
      if ({a_dma_gnt, a_cpu_stall, a_dbg_state, a_stall_cnt} !== {eg, eg, es, ec}) begin
        miscompares++;
        $display("FAIL burst c%0d: gnt/stall/state=%b stall_cnt=%0d want %b %0d",
                 c, {a_dma_gnt, a_cpu_stall, a_dbg_state}, a_stall_cnt, {eg, eg, es}, ec);
      end
      vectors++;
      if ({a_mem_addr, a_cpu_rdata} !== {(eg ? 32'h200 : 32'h100), (eg ? 32'h0 : 32'hCAFEF00D)}) begin
        miscompares++;
        $display("FAIL burst_bus c%0d: mem_addr=%h cpu_rdata=%h", c, a_mem_addr, a_cpu_rdata);
      end
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic test_early_last();
    logic        eg, es;
    logic [15:0] ec;
    drive_contention(1'b1);
    for (int c = 0; c <= 19; c++) begin
      dma_last = (c >= 9);
      eg = (c == 8) || (c == 9) || (c == 18);
      es = (c == 9);
      ec = (c <= 8) ? 16'd4 : (c == 9) ? 16'd5 : (c <= 18) ? 16'd6 : 16'd7;
      @(negedge clk);
      vectors++;
      if ({a_dma_gnt, a_cpu_stall, a_dbg_state, a_stall_cnt} !== {eg, eg, es, ec}) begin
        miscompares++;
        $display("FAIL early_last c%0d: gnt/stall/state=%b stall_cnt=%0d want %b %0d",
                 c, {a_dma_gnt, a_cpu_stall, a_dbg_state}, a_stall_cnt, {eg, eg, es}, ec);
      end
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic test_dma_read();
    dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 32'h20; mem_rdata = 32'h12345678;
    @(negedge clk);
    vectors++;
    if ({a_dma_gnt, a_mem_rd, a_mem_wr, a_mem_addr, a_cpu_rdata} !== {3'b110, 32'h20, 32'h0}) begin
      miscompares++;
      $display("FAIL dma_read_beat: gnt/rd/wr=%b addr=%h cpu_rdata=%h want 110 20 0",
               {a_dma_gnt, a_mem_rd, a_mem_wr}, a_mem_addr, a_cpu_rdata);
    end
    step();
    drive_idle();
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    vectors++;
    if ({a_dma_rvalid, a_dma_rdata} !== {1'b1, 32'h12345678}) begin
      miscompares++;
      $display("FAIL dma_read_data: rvalid=%b rdata=%h want 1 12345678", a_dma_rvalid, a_dma_rdata);
    end
    step();
    @(negedge clk);
    vectors++;
    if ({a_dma_rvalid, a_dma_rdata} !== {1'b0, 32'h12345678}) begin
      miscompares++;
      $display("FAIL dma_read_hold: rvalid=%b rdata=%h want 0 12345678", a_dma_rvalid, a_dma_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    drive_contention(1'b0);
    for (int c = 0; c <= 9; c++) step();
    vectors++;
    if ({a_dbg_state, a_dma_rvalid, a_cpu_stall, a_stall_cnt} !== {3'b111, 16'd9}) begin
      miscompares++;
      $display("FAIL pre_reset_burst: state/rvalid/stall=%b stall_cnt=%0d want 111 9",
               {a_dbg_state, a_dma_rvalid, a_cpu_stall}, a_stall_cnt);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({a_dbg_state, a_cpu_stall, a_dma_gnt, a_dma_rvalid, a_stall_cnt, a_dma_rdata} !== 52'h0) begin
      miscompares++;
      $display("FAIL reset_mid_burst: state/stall/gnt/rvalid=%b stall_cnt=%0d rdata=%h want 0",
               {a_dbg_state, a_cpu_stall, a_dma_gnt, a_dma_rvalid}, a_stall_cnt, a_dma_rdata);
    end
    step();
    reset = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      vectors++;
      if ({a_dma_gnt, a_cpu_stall} !== {2{c == 8}}) begin
        miscompares++;
        $display("FAIL post_reset c%0d: gnt/stall=%b want %b", c, {a_dma_gnt, a_cpu_stall}, {2{c == 8}});
      end
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic test_max_wait_zero();
    logic [15:0] ec;
    reset = 1'b0;
    drive_contention(1'b1);
    step();
    reset = 1'b1;
    for (int c = 0; c <= 65537; c++) begin
      @(negedge clk);
      if ((c < 4) || (c >= 65533)) begin
        ec = (c >= 65535) ? 16'hFFFF : 16'(c);
        vectors++;
        if ({b_dma_gnt, b_cpu_stall, b_dbg_state, b_stall_cnt} !== {3'b110, ec}) begin
          miscompares++;
          $display("FAIL max_wait0 c%0d: gnt/stall/state=%b stall_cnt=%h want 110 %h",
                   c, {b_dma_gnt, b_cpu_stall, b_dbg_state}, b_stall_cnt, ec);
        end
      end
      step();
    end
    drive_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_passthrough();
    test_dma_idle_write();
    test_forced_burst();
    test_early_last();
    test_dma_read();
    test_reset_mid_burst();
    test_max_wait_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
